// File: rtl/alu_response_recorder.sv
// ============================================================================
// Module   : alu_response_recorder
// Function : Captures valid ALU_System response samples into a FWFT FIFO that
//            a ready/valid port drains; optional comparator via REC_COMPARE_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_response_recorder #(
    parameter int DEPTH       = 16,
    parameter int MAX_SAMPLES = 0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Stop,
    input  logic                      SampleValid,
    input  logic [7:0]                ALUOut,
    input  logic [3:0]                ALUOutFlag,
    input  logic [7:0]                Address,
    input  logic [7:0]                MemoryOut,
    input  logic [7:0]                MuxCOut,
    input  logic [35:0]               ExpData,
    input  logic                      RdReady,
    output logic                      RdValid,
    output logic [35:0]               RdData,
    output logic [7:0]                RdTag,
    output logic [$clog2(DEPTH):0]    Count,
    output logic                      Busy,
    output logic                      Overflow,
    output logic [7:0]                MismatchCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      tag_q, tag_d;
    logic [31:0]     samp_cnt_q, samp_cnt_d;
    logic            ovf_q, ovf_d;

    logic [35:0]     data_mem_q [DEPTH];
    logic [7:0]      tag_mem_q  [DEPTH];

    logic [35:0]     w_packed;
    logic            w_sample;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;

    assign w_packed = {ALUOutFlag, ALUOut, Address, MemoryOut, MuxCOut};
    assign w_sample = (state_q == ST_CAPTURE) && SampleValid;
    assign w_pop    = (count_q != '0) && RdReady;
    assign w_full   = (count_q == CW'(DEPTH));
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_wr     = w_sample && (!w_full || w_pop);

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        samp_cnt_d = samp_cnt_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q + {{(AW-1){1'b0}}, w_wr};
        rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, w_pop};
        unique case ({w_wr, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (Start && !Stop) begin
                    state_d    = ST_CAPTURE;
                    tag_d      = 8'h00;
                    samp_cnt_d = 32'd0;
                    ovf_d      = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (w_sample) begin
                    tag_d      = tag_q + 8'h01;
                    samp_cnt_d = samp_cnt_q + 32'd1;
                    if (!w_wr) begin
                        ovf_d = 1'b1;
                    end
                    if ((MAX_SAMPLES != 0) && (samp_cnt_q == 32'(MAX_SAMPLES - 1))) begin
                        state_d = ST_IDLE;
                    end
                end
                if (Stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tag_q      <= 8'h00;
            samp_cnt_q <= 32'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tag_q      <= tag_d;
            samp_cnt_q <= samp_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only visible while Count covers them.
    always_ff @(posedge Clock) begin
        if (Reset && w_wr) begin
            data_mem_q[wr_ptr_q] <= w_packed;
            tag_mem_q[wr_ptr_q]  <= tag_q;
        end
    end

`ifdef REC_COMPARE_EN
    logic [7:0] mismatch_q, mismatch_d;

    always_comb begin
        mismatch_d = mismatch_q;
        if ((state_q == ST_IDLE) && Start && !Stop) begin
            mismatch_d = 8'h00;
        end else if (w_sample && (w_packed != ExpData) && (mismatch_q != 8'hFF)) begin
            mismatch_d = mismatch_q + 8'h01;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            mismatch_q <= 8'h00;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign MismatchCount = mismatch_q;
`else
    logic unused_expdata;
    assign unused_expdata = ^ExpData;
    assign MismatchCount  = 8'h00;
`endif

    assign RdValid  = (count_q != '0);
    assign RdData   = RdValid ? data_mem_q[rd_ptr_q] : 36'h0;
    assign RdTag    = RdValid ? tag_mem_q[rd_ptr_q]  : 8'h00;
    assign Count    = count_q;
    assign Busy     = (state_q == ST_CAPTURE);
    assign Overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_response_recorder.sv
// ============================================================================
// Module   : tb_alu_response_recorder
// Function : Directed self-checking bench for alu_response_recorder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_response_recorder;

    logic        clk = 1'b0;
    logic        r_rst_n = 1'b0;
    logic        r_start = 1'b0;
    logic        r_stop = 1'b0;
    logic        r_valid = 1'b0;
    logic [7:0]  r_alu = 8'h00;
    logic [3:0]  r_flag = 4'h0;
    logic [7:0]  r_addr = 8'h00;
    logic [7:0]  r_mem = 8'h00;
    logic [7:0]  r_muxc = 8'h00;
    logic [35:0] r_exp = 36'h0;
    logic        r_rd_ready = 1'b0;

    logic        w_rd_valid, w_busy, w_ovf;
    logic [35:0] w_rd_data;
    logic [7:0]  w_rd_tag, w_mis;
    logic [4:0]  w_count;

    logic        w_ms_rd_valid, w_ms_busy, w_ms_ovf;
    logic [35:0] w_ms_rd_data;
    logic [7:0]  w_ms_rd_tag, w_ms_mis;
    logic [4:0]  w_ms_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_response_recorder #(.DEPTH(16), .MAX_SAMPLES(0)) dut (
        .Clock(clk), .Reset(r_rst_n), .Start(r_start), .Stop(r_stop),
        .SampleValid(r_valid), .ALUOut(r_alu), .ALUOutFlag(r_flag),
        .Address(r_addr), .MemoryOut(r_mem), .MuxCOut(r_muxc), .ExpData(r_exp),
        .RdReady(r_rd_ready), .RdValid(w_rd_valid), .RdData(w_rd_data),
        .RdTag(w_rd_tag), .Count(w_count), .Busy(w_busy), .Overflow(w_ovf),
        .MismatchCount(w_mis)
    );

    alu_response_recorder #(.DEPTH(16), .MAX_SAMPLES(4)) dut_ms (
        .Clock(clk), .Reset(r_rst_n), .Start(r_start), .Stop(r_stop),
        .SampleValid(r_valid), .ALUOut(r_alu), .ALUOutFlag(r_flag),
        .Address(r_addr), .MemoryOut(r_mem), .MuxCOut(r_muxc), .ExpData(r_exp),
        .RdReady(r_rd_ready), .RdValid(w_ms_rd_valid), .RdData(w_ms_rd_data),
        .RdTag(w_ms_rd_tag), .Count(w_ms_count), .Busy(w_ms_busy), .Overflow(w_ms_ovf),
        .MismatchCount(w_ms_mis)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input logic [7:0] alu);
        r_alu  = alu;
        r_flag = 4'h0;
        r_addr = 8'h11;
        r_mem  = 8'h22;
        r_muxc = 8'h33;
        r_exp  = {4'h0, alu, 8'h11, 8'h22, 8'h33};
    endtask

    task automatic do_reset();
        r_valid = 1'b0; r_start = 1'b0; r_stop = 1'b0; r_rd_ready = 1'b0;
        r_rst_n = 1'b0;
        tick();
        r_rst_n = 1'b1;
    endtask

    task automatic start_run();
        r_start = 1'b1;
        tick();
        r_start = 1'b0;
    endtask

    task automatic stop_run();
        r_valid = 1'b0;
        r_stop  = 1'b1;
        tick();
        r_stop  = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_rdvalid", 64'(w_rd_valid), 64'd0);
        check("rst_rddata",  64'(w_rd_data),  64'd0);
        check("rst_rdtag",   64'(w_rd_tag),   64'd0);
        check("rst_count",   64'(w_count),    64'd0);
        check("rst_busy",    64'(w_busy),     64'd0);
        check("rst_ovf",     64'(w_ovf),      64'd0);
        check("rst_mis",     64'(w_mis),      64'd0);
        r_rst_n = 1'b1;

        // Three samples, no reads, then a single pop
        start_run();
        check("t1_busy", 64'(w_busy), 64'd1);
        r_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_sample(8'h05 + 8'(i));
            tick();
        end
        r_valid = 1'b0;
        check("t1_count",  64'(w_count),    64'd3);
        check("t1_tag",    64'(w_rd_tag),   64'd0);
        check("t1_data",   64'(w_rd_data),  64'h005112233);
        check("t1_valid",  64'(w_rd_valid), 64'd1);
        tick();
        check("t1_stable", 64'(w_rd_data),  64'h005112233);
        r_rd_ready = 1'b1;
        tick();
        r_rd_ready = 1'b0;
        check("t1_pop_tag",   64'(w_rd_tag),  64'd1);
        check("t1_pop_data",  64'(w_rd_data), 64'h006112233);
        check("t1_pop_count", 64'(w_count),   64'd2);
        stop_run();
        check("t1_idle", 64'(w_busy), 64'd0);

        // 17 samples into a 16-deep FIFO, then drain
        do_reset();
        start_run();
        r_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_sample(8'(i));
            tick();
        end
        stop_run();
        check("t2_count", 64'(w_count), 64'd16);
        check("t2_ovf",   64'(w_ovf),   64'd1);
        r_rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t2_pop_tag", 64'(w_rd_tag),          64'(i));
            check("t2_pop_alu", 64'(w_rd_data[31:24]),  64'(i));
            tick();
        end
        check("t2_empty_valid", 64'(w_rd_valid), 64'd0);
        tick(); tick();
        check("t2_no_underflow", 64'(w_count), 64'd0);

        // Write into empty with RdReady high, then full with simultaneous pop
        start_run();
        check("t3_ovf_cleared", 64'(w_ovf), 64'd0);
        r_valid = 1'b1;
        set_sample(8'hA0);
        tick();
        check("t3_empty_write", 64'(w_count), 64'd1);
        tick();
        check("t3_write_pop", 64'(w_count), 64'd1);
        r_rd_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("t3_full",       64'(w_count), 64'd16);
        check("t3_full_noovf", 64'(w_ovf),   64'd0);
        r_rd_ready = 1'b1;
        tick();
        check("t3_wp_count", 64'(w_count),  64'd16);
        check("t3_wp_ovf",   64'(w_ovf),    64'd0);
        check("t3_wp_head",  64'(w_rd_tag), 64'd2);
        r_rd_ready = 1'b0;
        tick();
        check("t3_drop_ovf",   64'(w_ovf),   64'd1);
        check("t3_drop_count", 64'(w_count), 64'd16);
        stop_run();

        // Auto-stop after MAX_SAMPLES=4
        do_reset();
        start_run();
        r_valid = 1'b1;
        set_sample(8'h10);
        for (int i = 0; i < 3; i++) tick();
        check("t4_busy_3", 64'(w_ms_busy),  64'd1);
        check("t4_count_3", 64'(w_ms_count), 64'd3);
        tick();
        check("t4_busy_4",  64'(w_ms_busy),  64'd0);
        check("t4_count_4", 64'(w_ms_count), 64'd4);
        tick();
        check("t4_count_hold", 64'(w_ms_count), 64'd4);
        r_valid = 1'b0;
        r_start = 1'b1; r_stop = 1'b1;
        tick();
        r_start = 1'b0; r_stop = 1'b0;
        check("t4_start_stop", 64'(w_ms_busy), 64'd0);
        check("t4_start_stop_main", 64'(w_busy), 64'd0);

        // Reset in the middle of a run
        do_reset();
        start_run();
        r_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t5_count_pre", 64'(w_count), 64'd5);
        r_rst_n = 1'b0;
        tick();
        check("t5_count", 64'(w_count),    64'd0);
        check("t5_valid", 64'(w_rd_valid), 64'd0);
        check("t5_busy",  64'(w_busy),     64'd0);
        check("t5_data",  64'(w_rd_data),  64'd0);
        r_rst_n = 1'b1;
        r_valid = 1'b0;

        // Comparator: three wrong expectations out of ten
        start_run();
        r_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_sample(8'h40 + 8'(i));
            if (i == 2 || i == 5 || i == 8) r_exp = r_exp ^ 36'h1;
            tick();
        end
        stop_run();
`ifdef REC_COMPARE_EN
        check("t6_mismatch", 64'(w_mis), 64'd3);
`else
        check("t6_mismatch", 64'(w_mis), 64'd0);
`endif
        check("t6_count", 64'(w_count), 64'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
